// File: rtl/rv_g_pkg.sv
// Shared types and helpers for the rv_g register-file front end.
package rv_g_pkg;

  // Register address: bit 5 selects the FP file, bits 4:0 the register.
  typedef logic [5:0] reg_addr_t;

  // Issue-side arbitration state.
  typedef enum logic {
    ISS_IDLE = 1'b0,
    ISS_HOLD = 1'b1
  } iss_state_t;

  // Widest request vector rr_sel can scan.
  localparam int unsigned RR_MAX = 8;

  // Round-robin pick: the first set bit of vld at or after ptr, wrapping at n.
  // Returns 0 when nothing is valid; callers qualify with |vld.
  function automatic logic [2:0] rr_sel(input logic [RR_MAX-1:0] vld,
                                        input logic [2:0]        ptr,
                                        input int unsigned       n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && (k < n) && vld[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns its pointer, picks the first valid requester at
// or after it, and moves the pointer past `base` when told to advance.
module rr_arbiter
  import rv_g_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic [N-1:0]  valid,
  input  logic          advance,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic [IW-1:0] ptr
);

  logic [RR_MAX-1:0] vld_ext;
  logic [2:0]        ptr_ext;
  logic [2:0]        pick;

  // Widen to the helper's fixed width and decode the pick.
  always_comb begin
    vld_ext          = '0;
    vld_ext[N-1:0]   = valid;
    ptr_ext          = '0;
    ptr_ext[IW-1:0]  = ptr;
    pick             = rr_sel(vld_ext, ptr_ext, N);
    any              = |valid;
    onehot           = '0;
    idx              = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (any && (pick == 3'(i))) begin
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

  // Pointer moves to the slot after `base`, wrapping at N.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (base == IW'(N - 1)) ? '0 : base + 1'b1;
    end
  end

endmodule

// File: rtl/rv_g_regfile_arb.sv
// Shares the regfile's single issue port among NUM_REQ requesters and its
// single write port among NUM_WB writeback sources, both round-robin.
// Handshake: a requester is served in the cycle where its valid is high and
// its grant/ready bit is high; both sides answer combinationally in that
// cycle, and a valid must stay asserted (with stable addresses) until served.
module rv_g_regfile_arb
  import rv_g_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned NUM_WB      = 2,
  parameter  int unsigned XLEN        = 64,
  parameter  int unsigned FLEN        = 64,
  parameter  int unsigned STALL_LIMIT = 8,
  localparam int unsigned MaxLen      = (XLEN > FLEN) ? XLEN : FLEN,
  localparam int unsigned IIW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned WIW         = (NUM_WB > 1) ? $clog2(NUM_WB) : 1,
  localparam int unsigned SW          = $clog2(STALL_LIMIT + 1)
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  reg_addr_t [NUM_REQ-1:0]        req_rd_addr_i,
  input  reg_addr_t [NUM_REQ-1:0]        req_rs1_addr_i,
  input  reg_addr_t [NUM_REQ-1:0]        req_rs2_addr_i,
  input  reg_addr_t [NUM_REQ-1:0]        req_rs3_addr_i,
  output logic [NUM_REQ-1:0]             req_gnt_o,
  output logic [MaxLen-1:0]              rs1_data_o,
  output logic [MaxLen-1:0]              rs2_data_o,
  output logic [MaxLen-1:0]              rs3_data_o,
  input  logic [NUM_WB-1:0]              wb_valid_i,
  input  reg_addr_t [NUM_WB-1:0]         wb_addr_i,
  input  logic [NUM_WB-1:0][MaxLen-1:0]  wb_data_i,
  output logic [NUM_WB-1:0]              wb_ready_o,
  output logic                           rf_req_o,
  output reg_addr_t                      rf_rd_addr_o,
  output reg_addr_t                      rf_rs1_addr_o,
  output reg_addr_t                      rf_rs2_addr_o,
  output reg_addr_t                      rf_rs3_addr_o,
  input  logic                           rf_gnt_i,
  input  logic [MaxLen-1:0]              rf_rs1_data_i,
  input  logic [MaxLen-1:0]              rf_rs2_data_i,
  input  logic [MaxLen-1:0]              rf_rs3_data_i,
  output logic                           rf_wr_en_o,
  output reg_addr_t                      rf_wr_addr_o,
  output logic [MaxLen-1:0]              rf_wr_data_o,
  output iss_state_t                     dbg_state_o,
  output logic [IIW-1:0]                 dbg_iss_ptr_o,
  output logic [WIW-1:0]                 dbg_wb_ptr_o
);

  iss_state_t         state_q, state_d;
  logic [IIW-1:0]     sel_q, sel_d, cur_sel;
  logic [SW-1:0]      stall_q, stall_d;
  logic               have_sel, gnt, iss_adv;
  logic [NUM_REQ-1:0] iss_onehot;
  logic [IIW-1:0]     iss_idx;
  logic               iss_any;
  logic [WIW-1:0]     wb_idx;
  logic               wb_any;

  rr_arbiter #(.N(NUM_REQ)) u_iss_arb (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .valid   (req_valid_i),
    .advance (iss_adv),
    .base    (cur_sel),
    .onehot  (iss_onehot),
    .idx     (iss_idx),
    .any     (iss_any),
    .ptr     (dbg_iss_ptr_o)
  );

  rr_arbiter #(.N(NUM_WB)) u_wb_arb (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .valid   (wb_valid_i),
    .advance (wb_any),
    .base    (wb_idx),
    .onehot  (wb_ready_o),
    .idx     (wb_idx),
    .any     (wb_any),
    .ptr     (dbg_wb_ptr_o)
  );

  // Issue FSM: next state, stall counting and regfile-facing outputs.
  always_comb begin
    cur_sel  = iss_idx;
    have_sel = iss_any;
    if (state_q == ISS_HOLD) begin
      cur_sel  = sel_q;
      have_sel = req_valid_i[sel_q];
    end
    gnt      = have_sel & rf_gnt_i;
    state_d  = state_q;
    sel_d    = sel_q;
    stall_d  = stall_q;
    iss_adv  = 1'b0;
    if (gnt) begin
      state_d = ISS_IDLE;
      stall_d = '0;
      iss_adv = 1'b1;
    end else if (have_sel) begin
      if (state_q == ISS_IDLE) begin
        sel_d = cur_sel;
        if (STALL_LIMIT <= 1) begin
          // A limit of one stall rotates straight away.
          iss_adv = 1'b1;
          stall_d = '0;
        end else begin
          state_d = ISS_HOLD;
          stall_d = SW'(1);
        end
      end else if (stall_q == SW'(STALL_LIMIT - 1)) begin
        // Blocked long enough: give the others a turn.
        state_d = ISS_IDLE;
        stall_d = '0;
        iss_adv = 1'b1;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end else begin
      // Held requester withdrew: drop back without moving the pointer.
      state_d = ISS_IDLE;
      stall_d = '0;
    end

    rf_req_o      = have_sel;
    rf_rd_addr_o  = have_sel ? req_rd_addr_i[cur_sel]  : '0;
    rf_rs1_addr_o = have_sel ? req_rs1_addr_i[cur_sel] : '0;
    rf_rs2_addr_o = have_sel ? req_rs2_addr_i[cur_sel] : '0;
    rf_rs3_addr_o = have_sel ? req_rs3_addr_i[cur_sel] : '0;
    req_gnt_o     = '0;
    if (gnt) begin
      if (state_q == ISS_IDLE) req_gnt_o = iss_onehot;
      else                     req_gnt_o[sel_q] = 1'b1;
    end
    rs1_data_o = gnt ? rf_rs1_data_i : '0;
    rs2_data_o = gnt ? rf_rs2_data_i : '0;
    rs3_data_o = gnt ? rf_rs3_data_i : '0;
  end

  // Writeback mux: one accepted source per cycle.
  always_comb begin
    rf_wr_en_o   = wb_any;
    rf_wr_addr_o = wb_any ? wb_addr_i[wb_idx] : '0;
    rf_wr_data_o = wb_any ? wb_data_i[wb_idx] : '0;
  end

  // Issue FSM state, latched selection and stall counter.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ISS_IDLE;
      sel_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      stall_q <= stall_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rv_g_regfile_arb.sv
// Directed bench for rv_g_regfile_arb with a small lock/forwarding regfile
// model on the rf_* side and queue-based checking of grants and accepts.
module tb_rv_g_regfile_arb;
  import rv_g_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic arst_ni;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]          req_valid_i;
  reg_addr_t [3:0]     req_rd_addr_i, req_rs1_addr_i, req_rs2_addr_i, req_rs3_addr_i;
  logic [3:0]          req_gnt_o;
  logic [63:0]         rs1_data_o, rs2_data_o, rs3_data_o;
  logic [1:0]          wb_valid_i;
  reg_addr_t [1:0]     wb_addr_i;
  logic [1:0][63:0]    wb_data_i;
  logic [1:0]          wb_ready_o;
  logic                rf_req_o;
  reg_addr_t           rf_rd_addr_o, rf_rs1_addr_o, rf_rs2_addr_o, rf_rs3_addr_o;
  logic                rf_gnt_i;
  logic [63:0]         rf_rs1_data_i, rf_rs2_data_i, rf_rs3_data_i;
  logic                rf_wr_en_o;
  reg_addr_t           rf_wr_addr_o;
  logic [63:0]         rf_wr_data_o;
  iss_state_t          dbg_state_o;
  logic [1:0]          dbg_iss_ptr_o;
  logic [0:0]          dbg_wb_ptr_o;

  rv_g_regfile_arb dut (
    .clk_i          (clk),
    .arst_ni        (arst_ni),
    .req_valid_i    (req_valid_i),
    .req_rd_addr_i  (req_rd_addr_i),
    .req_rs1_addr_i (req_rs1_addr_i),
    .req_rs2_addr_i (req_rs2_addr_i),
    .req_rs3_addr_i (req_rs3_addr_i),
    .req_gnt_o      (req_gnt_o),
    .rs1_data_o     (rs1_data_o),
    .rs2_data_o     (rs2_data_o),
    .rs3_data_o     (rs3_data_o),
    .wb_valid_i     (wb_valid_i),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .wb_ready_o     (wb_ready_o),
    .rf_req_o       (rf_req_o),
    .rf_rd_addr_o   (rf_rd_addr_o),
    .rf_rs1_addr_o  (rf_rs1_addr_o),
    .rf_rs2_addr_o  (rf_rs2_addr_o),
    .rf_rs3_addr_o  (rf_rs3_addr_o),
    .rf_gnt_i       (rf_gnt_i),
    .rf_rs1_data_i  (rf_rs1_data_i),
    .rf_rs2_data_i  (rf_rs2_data_i),
    .rf_rs3_data_i  (rf_rs3_data_i),
    .rf_wr_en_o     (rf_wr_en_o),
    .rf_wr_addr_o   (rf_wr_addr_o),
    .rf_wr_data_o   (rf_wr_data_o),
    .dbg_state_o    (dbg_state_o),
    .dbg_iss_ptr_o  (dbg_iss_ptr_o),
    .dbg_wb_ptr_o   (dbg_wb_ptr_o)
  );

  // ---------------- regfile model ----------------
  // Unwritten registers read as 0x1000 + address; a grant locks rd (x0 never
  // locks), a write stores and unlocks; same-cycle writes forward to reads.
  bit [63:0] regs    [64];
  bit        wr_seen [64];
  bit        lock    [64];

  assign rf_gnt_i = rf_req_o && !lock[rf_rd_addr_o] && !lock[rf_rs1_addr_o]
                    && !lock[rf_rs2_addr_o] && !lock[rf_rs3_addr_o];

  assign rf_rs1_data_i = (rf_wr_en_o && rf_wr_addr_o == rf_rs1_addr_o) ? rf_wr_data_o :
                         wr_seen[rf_rs1_addr_o] ? regs[rf_rs1_addr_o] : 64'h1000 + 64'(rf_rs1_addr_o);
  assign rf_rs2_data_i = (rf_wr_en_o && rf_wr_addr_o == rf_rs2_addr_o) ? rf_wr_data_o :
                         wr_seen[rf_rs2_addr_o] ? regs[rf_rs2_addr_o] : 64'h1000 + 64'(rf_rs2_addr_o);
  assign rf_rs3_data_i = (rf_wr_en_o && rf_wr_addr_o == rf_rs3_addr_o) ? rf_wr_data_o :
                         wr_seen[rf_rs3_addr_o] ? regs[rf_rs3_addr_o] : 64'h1000 + 64'(rf_rs3_addr_o);

  always @(posedge clk) begin
    if (rf_wr_en_o) begin
      regs[rf_wr_addr_o]    <= rf_wr_data_o;
      wr_seen[rf_wr_addr_o] <= 1'b1;
      lock[rf_wr_addr_o]    <= 1'b0;
    end
    if (rf_gnt_i && rf_rd_addr_o != 6'd0) lock[rf_rd_addr_o] <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [67:0] iss_exp_q[$];   // {req_gnt_o, rs1_data_o}
  logic [71:0] wb_exp_q[$];    // {wb_ready_o, rf_wr_addr_o, rf_wr_data_o}
  logic [67:0] iss_e;
  logic [71:0] wb_e;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever the DUT grants or accepts.
  always @(negedge clk) begin
    if (req_gnt_o != 4'b0) begin
      if (iss_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL iss_unexpected: got gnt=%b data=%0h expected no grant at %0t",
                 req_gnt_o, rs1_data_o, $time);
      end else begin
        iss_e = iss_exp_q.pop_front();
        check("iss_grant", {60'd0, req_gnt_o, rs1_data_o}, {60'd0, iss_e});
      end
    end
    if (wb_ready_o != 2'b0) begin
      if (wb_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got ready=%b addr=%0d expected no accept at %0t",
                 wb_ready_o, rf_wr_addr_o, $time);
      end else begin
        wb_e = wb_exp_q.pop_front();
        check("wb_accept", {56'd0, wb_ready_o, rf_wr_addr_o, rf_wr_data_o}, {56'd0, wb_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] rd, input logic [5:0] rs1);
    req_rd_addr_i[i]  = rd;
    req_rs1_addr_i[i] = rs1;
    req_rs2_addr_i[i] = 6'd0;
    req_rs3_addr_i[i] = 6'd0;
  endtask

  task automatic expect_iss(input logic [3:0] g, input logic [63:0] d);
    iss_exp_q.push_back({g, d});
  endtask

  task automatic expect_wb(input logic [1:0] r, input logic [5:0] a, input logic [63:0] d);
    wb_exp_q.push_back({r, a, d});
  endtask

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    arst_ni        = 1'b0;
    req_valid_i    = '0;
    req_rd_addr_i  = '0;
    req_rs1_addr_i = '0;
    req_rs2_addr_i = '0;
    req_rs3_addr_i = '0;
    wb_valid_i     = '0;
    wb_addr_i      = '0;
    wb_data_i      = '0;
    repeat (2) @(posedge clk);
    #1 arst_ni = 1'b1;

    // Reset state: every output 0 for 10 cycles with nothing valid.
    for (int c = 0; c < 10; c++) begin
      step();
      #3;
      check("rst_ctrl", {req_gnt_o, wb_ready_o, rf_req_o, rf_wr_en_o, rf_rd_addr_o,
                         rf_rs1_addr_o, rf_rs2_addr_o, rf_rs3_addr_o, rf_wr_addr_o}, 128'd0);
      check("rst_data", {127'd0, |{rs1_data_o, rs2_data_o, rs3_data_o, rf_wr_data_o}}, 128'd0);
    end
    check("rst_state", {126'd0, dbg_state_o}, {127'd0, ISS_IDLE});
    check("rst_ptrs", {dbg_iss_ptr_o, dbg_wb_ptr_o}, 128'd0);

    // Writeback both valid for 4 cycles: ready 01,10,01,10.
    step();
    wb_valid_i   = 2'b11;
    wb_addr_i[0] = 6'd30;
    wb_data_i[0] = 64'hAAAA_0000;
    wb_addr_i[1] = 6'd31;
    wb_data_i[1] = 64'hBBBB_0001;
    expect_wb(2'b01, 6'd30, 64'hAAAA_0000); step();
    expect_wb(2'b10, 6'd31, 64'hBBBB_0001); step();
    expect_wb(2'b01, 6'd30, 64'hAAAA_0000); step();
    expect_wb(2'b10, 6'd31, 64'hBBBB_0001); step();
    wb_valid_i = 2'b00;

    // All four requesting, disjoint sources, rd=x0: grants 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_req(i, 6'd0, 6'(1 + i));
    req_valid_i = 4'b1111;
    expect_iss(4'b0001, 64'h1001); step();
    expect_iss(4'b0010, 64'h1002); step();
    expect_iss(4'b0100, 64'h1003); step();
    expect_iss(4'b1000, 64'h1004); step();
    expect_iss(4'b0001, 64'h1001); step();
    req_valid_i = 4'b0000;

    // Requester 0 locks x20 (iss_ptr is 1, so it is reached by wrapping).
    set_req(0, 6'd20, 6'd1);
    req_valid_i = 4'b0001;
    expect_iss(4'b0001, 64'h1001);
    step();

    // Requester 1 reads x20 and stalls 8 cycles; requester 2 then goes.
    set_req(1, 6'd0, 6'd20);
    set_req(2, 6'd0, 6'd3);
    req_valid_i = 4'b0110;
    for (int c = 1; c <= 8; c++) begin
      #3;
      check("stall_hold", {req_gnt_o, rf_req_o, rf_rs1_addr_o}, {4'b0000, 1'b1, 6'd20});
      if (c == 5) check("stall_state", {126'd0, dbg_state_o}, {127'd0, ISS_HOLD});
      step();
    end
    expect_iss(4'b0100, 64'h1003);
    #3;
    check("rotate_gnt", {124'd0, req_gnt_o}, 128'b0100);
    step();

    // Requester 1 reselected while still locked; x20 written this cycle.
    req_valid_i  = 4'b0010;
    wb_valid_i   = 2'b01;
    wb_addr_i[0] = 6'd20;
    wb_data_i[0] = 64'hBEEF;
    expect_wb(2'b01, 6'd20, 64'hBEEF);
    #3;
    check("relock_wait", {124'd0, req_gnt_o}, 128'd0);
    step();
    wb_valid_i = 2'b00;
    expect_iss(4'b0010, 64'hBEEF);
    step();
    req_valid_i = 4'b0000;

    // Same-cycle write x5=0xDEAD (source 1, wb_ptr is 1) and issue reading x5.
    set_req(2, 6'd0, 6'd5);
    req_valid_i  = 4'b0100;
    wb_valid_i   = 2'b10;
    wb_addr_i[1] = 6'd5;
    wb_data_i[1] = 64'hDEAD;
    expect_iss(4'b0100, 64'hDEAD);
    expect_wb(2'b10, 6'd5, 64'hDEAD);
    #3;
    check("fwd_data", {64'd0, rs1_data_o}, {64'd0, 64'hDEAD});
    step();
    req_valid_i = 4'b0000;
    wb_valid_i  = 2'b00;

    // Requester 1 locks x40 (iss_ptr 3 wraps to 1), requester 2 stalls on it.
    set_req(1, 6'd40, 6'd7);
    req_valid_i = 4'b0010;
    expect_iss(4'b0010, 64'h1007);
    step();
    set_req(2, 6'd0, 6'd40);
    req_valid_i = 4'b0100;
    step();
    step();
    #3;
    check("pre_rst_hold", {dbg_state_o, dbg_iss_ptr_o}, {ISS_HOLD, 2'd2});
    arst_ni = 1'b0;
    #1;
    check("mid_rst_state", {126'd0, dbg_state_o}, {127'd0, ISS_IDLE});
    check("mid_rst_ptr", {126'd0, dbg_iss_ptr_o}, 128'd0);
    check("mid_rst_gnt", {124'd0, req_gnt_o}, 128'd0);
    req_valid_i = 4'b0000;
    step();
    arst_ni = 1'b1;
    step();
    step();

    check("iss_q_empty", 128'(iss_exp_q.size()), 128'd0);
    check("wb_q_empty", 128'(wb_exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
